// File: rtl/exotiny_ccx_pkg.sv
// Shared types and helpers for the ExoTiny CCX chunk-serial responder.
package exotiny_ccx_pkg;

  localparam int CCX_CHUNKSIZE = 4;
  localparam int CCX_XLEN      = 32;
  localparam int CCX_ACC_W     = 6;

  localparam logic CCX_SEL_HAMMING = 1'b0;
  localparam logic CCX_SEL_ROTL    = 1'b1;

  typedef enum logic [2:0] {
    CCX_IDLE,
    CCX_RECV,
    CCX_CALC,
    CCX_SEND,
    CCX_DRAIN
  } ccx_state_e;

  // Counts set bits of a chunk zero-extended into a 32-bit word.
  function automatic logic [CCX_ACC_W-1:0] popcnt_chunk(input logic [31:0] bits);
    logic [CCX_ACC_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + CCX_ACC_W'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/exotiny_ccx_resp.sv
// CCX responder: collects two operands chunk by chunk, computes Hamming
// distance or rotate-left, then streams the result back in the same order.
module exotiny_ccx_resp
  import exotiny_ccx_pkg::*;
#(
  parameter int CHUNKSIZE = CCX_CHUNKSIZE,
  parameter int XLEN      = CCX_XLEN
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ccx_req_i,
  input  logic [1:0]           ccx_sel_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o
);

  localparam int NB    = XLEN / CHUNKSIZE;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  ccx_state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt_q;
  logic [XLEN-1:0]      a_q, b_q, result_q;
  logic                 sel_q;
  logic [CCX_ACC_W-1:0] acc_q;
  logic [CCX_ACC_W-1:0] beat_pop;
  logic [2*XLEN-1:0]    rot_wide;
  logic [XLEN-1:0]      calc_result;
  logic [CHUNKSIZE-1:0] res_d;
  logic                 resp_d;
  logic                 capture;
  logic                 unused_ok;

  assign beat_pop  = popcnt_chunk(32'(ccx_rs_a_i ^ ccx_rs_b_i));
  assign rot_wide  = {a_q, a_q} << b_q[SH_W-1:0];
  assign calc_result = (sel_q == CCX_SEL_ROTL) ? rot_wide[2*XLEN-1:XLEN] : XLEN'(acc_q);
  assign capture   = ccx_req_i && ((state_q == CCX_IDLE) || (state_q == CCX_RECV));
  assign unused_ok = ^{ccx_sel_i[1], b_q[XLEN-1:SH_W]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CCX_IDLE;
      ccx_res_o  <= '0;
      ccx_resp_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      ccx_res_o  <= res_d;
      ccx_resp_o <= resp_d;
    end
  end

  // Outputs are registered from the next-state decision, so resp is high
  // exactly while the FSM sits in SEND and drops on the edge of an abort.
  always_comb begin
    state_d = state_q;
    res_d   = '0;
    resp_d  = 1'b0;
    unique case (state_q)
      CCX_IDLE: begin
        if (ccx_req_i) state_d = CCX_RECV;
      end
      CCX_RECV: begin
        if (!ccx_req_i)              state_d = CCX_IDLE;
        else if (cnt_q == CNT_LAST)  state_d = CCX_CALC;
      end
      CCX_CALC: begin
        if (!ccx_req_i) begin
          state_d = CCX_IDLE;
        end else begin
          state_d = CCX_SEND;
          resp_d  = 1'b1;
          res_d   = calc_result[CHUNKSIZE-1:0];
        end
      end
      CCX_SEND: begin
        if (!ccx_req_i) begin
          state_d = CCX_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CCX_DRAIN;
        end else begin
          resp_d = 1'b1;
          res_d  = result_q[2*CHUNKSIZE-1:CHUNKSIZE];
        end
      end
      CCX_DRAIN: begin
        if (!ccx_req_i) state_d = CCX_IDLE;
      end
      default: state_d = CCX_IDLE;
    endcase
  end

  // Operands shift in from the MSB side so chunk 0 lands at bit 0 after NB
  // beats; the result register shifts right so its low chunk is always next.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sel_q    <= CCX_SEL_HAMMING;
      acc_q    <= '0;
    end else begin
      if (capture) begin
        a_q <= {ccx_rs_a_i, a_q[XLEN-1:CHUNKSIZE]};
        b_q <= {ccx_rs_b_i, b_q[XLEN-1:CHUNKSIZE]};
      end
      unique case (state_q)
        CCX_IDLE: begin
          if (ccx_req_i) begin
            sel_q <= ccx_sel_i[0];
            acc_q <= beat_pop;
            cnt_q <= CNT_W'(1);
          end
        end
        CCX_RECV: begin
          if (ccx_req_i) begin
            acc_q <= acc_q + beat_pop;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CCX_CALC: begin
          result_q <= calc_result;
          cnt_q    <= '0;
        end
        CCX_SEND: begin
          result_q <= result_q >> CHUNKSIZE;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exotiny_ccx_resp.sv
// Scoreboard bench for exotiny_ccx_resp: directed cases plus random
// transactions checked against a word-level reference model.
module tb_exotiny_ccx_resp;

  localparam int CS = 4;
  localparam int XL = 32;
  localparam int NB = XL / CS;

  typedef struct {
    int          t;
    logic [31:0] res;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [CS-1:0] rs_a = '0;
  logic [CS-1:0] rs_b = '0;
  logic [CS-1:0] res;
  logic          resp;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b1;
  exp_t exp_q[$];

  exotiny_ccx_resp #(.CHUNKSIZE(CS), .XLEN(XL)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ccx_req_i  (req),
    .ccx_sel_i  (sel),
    .ccx_rs_a_i (rs_a),
    .ccx_rs_b_i (rs_b),
    .ccx_res_o  (res),
    .ccx_resp_o (resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] s);
    int n;
    if (s[0] == 1'b0) return 32'($countones(a ^ b));
    n = int'(b[4:0]);
    if (n == 0) return a;
    return (a << n) | (a >> (32 - n));
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // abort_at: -1 completes, 1..NB-1 drops req at that beat, NB drops it in CALC.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] s, input int abort_at, input int hold);
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        req  = 1'b0;
        rs_a = CS'($urandom);
        rs_b = CS'($urandom);
        @(posedge clk); #1;
        return;
      end
      req  = 1'b1;
      sel  = (k == 0) ? s : 2'($urandom);
      rs_a = a[k*CS +: CS];
      rs_b = b[k*CS +: CS];
      if (k == 0 && abort_at < 0) begin
        e.t   = cyc;
        e.res = ref_model(a, b, s);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    rs_a = CS'($urandom);
    rs_b = CS'($urandom);
    sel  = 2'($urandom);
    if (abort_at == NB) begin
      req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    repeat (NB + 1 + hold) begin
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: reassembles each response burst and compares against the queue.
  int          got = 0;
  bit          cur_valid = 1'b0;
  exp_t        cur;
  logic [31:0] word;

  always @(negedge clk) begin
    if (rst) begin
      got       = 0;
      cur_valid = 1'b0;
    end else if (mon_en) begin
      if (resp) begin
        if (got == 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            cur_valid = 1'b0;
            $display("[TB] FAIL unexpected_resp actual=resp_high res=0x%0h required=no_response (cyc %0d)",
                     res, cyc);
          end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
            check_output("latency", 32'(cyc), 32'(cur.t + NB + 1));
          end
          word = '0;
        end
        word[got*CS +: CS] = res;
        got++;
        if (got == NB) begin
          if (cur_valid) check_output("result", word, cur.res);
          got = 0;
        end
      end else begin
        check_output("idle_res", 32'(res), 32'h0);
        if (got != 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL resp_gap actual=%0d_chunks required=%0d_chunks (cyc %0d)", got, NB, cyc);
          got = 0;
        end
      end
    end
  end

  // Reset asserted while chunk 3 is on the bus must clear outputs at once.
  task automatic reset_mid_send(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r      = ref_model(a, b, 2'b01);
    mon_en = 1'b0;
    for (int k = 0; k < NB; k++) begin
      req  = 1'b1;
      sel  = 2'b01;
      rs_a = a[k*CS +: CS];
      rs_b = b[k*CS +: CS];
      @(posedge clk); #1;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_output("send_chunk3", 32'(res), 32'(r[3*CS +: CS]));
    check_output("send_resp", 32'(resp), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_res", 32'(res), 32'h0);
    check_output("async_rst_resp", 32'(resp), 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b;
    int          ab;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_res", 32'(res), 32'h0);
    check_output("reset_resp", 32'(resp), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(32'hFFFF0000, 32'h0000FFFF, 2'b00, -1, 0);
    apply_stimulus(32'h80000001, 32'h00000001, 2'b01, -1, 0);
    apply_stimulus(32'h80000001, 32'h00000020, 2'b01, -1, 0);
    apply_stimulus(32'hDEADBEEF, 32'h01234567, 2'b00, 4, 0);
    apply_stimulus(32'h12345678, 32'h12345678, 2'b00, -1, 0);
    apply_stimulus(32'hCAFEF00D, 32'h00000007, 2'b01, NB, 0);
    apply_stimulus(32'hA5A5A5A5, 32'h00000013, 2'b01, -1, 3);
    apply_stimulus(32'h0000000F, 32'hFFFFFFFF, 2'b00, -1, 0);
    apply_stimulus(32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10, -1, 0);
    reset_mid_send(32'h87654321, 32'h00000004);
    apply_stimulus(32'h13579BDF, 32'h0000001F, 2'b11, -1, 0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, NB) : -1;
      apply_stimulus(a, b, 2'($urandom), ab, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1;
    check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    check_output("no_partial", 32'(got), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
